// File: rtl/mnist_mac_pkg.sv
// Shared constants and types for the Q16.16 neuron MAC datapath.
//   Q_FRAC       : fractional bits of the Q16.16 format
//   Q_W          : total Q16.16 word width
//   Q_MAX/Q_MIN  : saturation limits of a Q16.16 word
//   state_t      : sequencer FSM states
package mnist_mac_pkg;

  localparam int Q_FRAC = 16;
  localparam int Q_W    = 32;

  localparam logic signed [Q_W-1:0] Q_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [Q_W-1:0] Q_MIN = 32'sh8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FINISH
  } state_t;

endpackage

// File: rtl/q16_mult_pipe.sv
// One-cycle registered Q16.16 multiplier.
//   clk  : rising-edge clock
//   rstn : synchronous active-low reset, clears the product register
//   a    : signed Q16.16 weight
//   b    : signed input sample, XBITS+1 bits, Q16.16
//   p    : registered (a*b)>>>16, full-width product with the low
//          fractional bits dropped (floors toward minus infinity)
module q16_mult_pipe
  import mnist_mac_pkg::*;
#(
  parameter int XBITS = 31
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic signed [Q_W-1:0]           a,
  input  logic signed [XBITS:0]           b,
  output logic signed [Q_W+XBITS-Q_FRAC:0] p
);

  logic signed [Q_W+XBITS:0] prod_p1;

  assign prod_p1 = a * b;

  // ---- stage p1 -> p2: product register ----
  // Taking the upper slice of a two's-complement value is an arithmetic
  // shift right, so the result is floored, not truncated toward zero.
  always_ff @(posedge clk) begin
    if (!rstn) p <= '0;
    else       p <= prod_p1[Q_W+XBITS:Q_FRAC];
  end

endmodule

// File: rtl/mac_sequencer.sv
// Sequences one neuron evaluation: walks the weight/input memories,
// multiply-accumulates every pair, adds the bias, saturates to Q16.16 and
// applies ReLU.
//   clk, rstn : clock, synchronous active-low reset
//   start     : request an evaluation (accepted only while idle)
//   busy      : evaluation in progress
//   addr      : shared read address for weight and input memories
//   w_rdata   : signed Q16.16 weight, one cycle after addr
//   x_rdata   : signed Q16.16 input, one cycle after addr
//   bias      : signed Q16.16 bias, sampled in the FINISH cycle
//   result    : ReLU output, held until the next completed evaluation
//   done      : one-cycle pulse when result updates
module mac_sequencer
  import mnist_mac_pkg::*;
#(
  parameter int N_INPUTS = 784,
  parameter int XBITS    = 31,
  parameter int ACC_W    = 64
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  output logic                    busy,
  output logic [15:0]             addr,
  input  logic signed [Q_W-1:0]   w_rdata,
  input  logic signed [XBITS:0]   x_rdata,
  input  logic signed [Q_W-1:0]   bias,
  output logic signed [Q_W-1:0]   result,
  output logic                    done
);

  localparam int          P_W  = Q_W + XBITS + 1 - Q_FRAC;
  localparam logic [15:0] LAST = 16'(N_INPUTS - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        clr_acc;

  logic                    vld_p1, vld_p2;
  logic signed [P_W-1:0]   prod_p2;
  logic signed [ACC_W-1:0] acc_p3;
  logic signed [ACC_W-1:0] sum_p3;

  function automatic logic signed [Q_W-1:0] sat_q16(input logic signed [ACC_W-1:0] v);
    if (v > ACC_W'(Q_MAX))      return Q_MAX;
    else if (v < ACC_W'(Q_MIN)) return Q_MIN;
    else                        return v[Q_W-1:0];
  endfunction

  function automatic logic signed [Q_W-1:0] relu(input logic signed [Q_W-1:0] v);
    return v[Q_W-1] ? '0 : v;
  endfunction

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // cnt walks the addresses in RUN and is reused to time the two DRAIN
  // cycles that let the last product clear the memory and multiply stages.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_acc   = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (start) begin
          clr_acc   = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          cnt_nxt   = '0;
          state_nxt = DRAIN;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      DRAIN: begin
        if (cnt == 16'd1) begin
          cnt_nxt   = '0;
          state_nxt = FINISH;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      FINISH: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // addr and busy decode registered state only, so start never reaches addr
  // combinationally.
  assign addr = (state == RUN) ? cnt : 16'd0;
  assign busy = (state != IDLE);

  // ---- stage p0 -> p1: memory read latency ----
  always_ff @(posedge clk) begin
    if (!rstn) vld_p1 <= 1'b0;
    else       vld_p1 <= (state == RUN);
  end

  // ---- stage p1 -> p2: registered multiply ----
  q16_mult_pipe #(
    .XBITS(XBITS)
  ) u_mult (
    .clk (clk),
    .rstn(rstn),
    .a   (w_rdata),
    .b   (x_rdata),
    .p   (prod_p2)
  );

  always_ff @(posedge clk) begin
    if (!rstn) vld_p2 <= 1'b0;
    else       vld_p2 <= vld_p1;
  end

  // ---- stage p2 -> p3: accumulate (wrapping) ----
  always_ff @(posedge clk) begin
    if (!rstn)       acc_p3 <= '0;
    else if (clr_acc) acc_p3 <= '0;
    else if (vld_p2)  acc_p3 <= acc_p3 + ACC_W'(prod_p2);
  end

  assign sum_p3 = acc_p3 + ACC_W'(bias);

  // ---- stage p3 -> output: bias, saturate, ReLU ----
  always_ff @(posedge clk) begin
    if (!rstn) begin
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= (state == FINISH);
      if (state == FINISH) result <= relu(sat_q16(sum_p3));
    end
  end

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 The block SHALL have parameter N_INPUTS, default 784: number of weight/input pairs per neuron, legal range 1..65535.
REQ-002 The block SHALL have parameter XBITS, default 31: input sample width is XBITS+1 signed bits, Q16.16.
REQ-003 The block SHALL have parameter ACC_W, default 64: signed accumulator width.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  request one neuron evaluation.
REQ-007 busy  output  1  high from the cycle after start is accepted until done.
REQ-008 addr  output  16  shared read address for weight and input memories.
REQ-009 w_rdata  input  32  signed Q16.16 weight, valid one cycle after addr.
REQ-010 x_rdata  input  XBITS+1  signed Q16.16 input, valid one cycle after addr.
REQ-011 bias  input  32  signed Q16.16 bias, sampled in the FINISH cycle.
REQ-012 result  output  32  signed Q16.16 ReLU output, held until the next accepted start.
REQ-013 done  output  1  one-cycle pulse marking result update.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, DRAIN and FINISH.
REQ-015 start SHALL be accepted only in IDLE. start in any other state SHALL be ignored with no effect.
REQ-016 Accepted start in cycle 0 SHALL clear the accumulator and enter RUN in cycle 1.
REQ-017 RUN SHALL drive addr = k in cycle k+1 for k = 0..N_INPUTS-1, then enter DRAIN.
REQ-018 Data for address k SHALL be multiplied in cycle k+2, computing (w*x)>>>16: full-width signed product, arithmetic shift, flooring.
REQ-019 The product SHALL be registered and then added to the accumulator at the end of cycle k+3. The accumulator SHALL be sign-extended and SHALL wrap without saturation.
REQ-020 DRAIN SHALL last 2 cycles, then the FSM SHALL enter FINISH in cycle N_INPUTS+3.
REQ-021 FINISH SHALL compute acc + sign-extended bias, saturate the sum to [0x80000000, 0x7FFFFFFF], apply ReLU (negative -> 0), and register the value into result.
REQ-022 done SHALL be high for exactly cycle N_INPUTS+4, with the FSM in IDLE. A start in that cycle SHALL be accepted.
REQ-023 addr SHALL hold 0 when not in RUN.
REQ-024 N_INPUTS=1 SHALL give a total latency of 5 cycles from start to done.

Reset
REQ-025 rstn low at a clock edge SHALL force the FSM to IDLE and clear accumulator, pipeline registers, addr, result, busy and done to 0. This SHALL apply in any state, including mid-RUN.
REQ-026 After reset release, the first start SHALL behave identically to a start from power-on.

Structure
REQ-027 Package mnist_mac_pkg SHALL hold Q_FRAC=16, the Q16.16 width constant, the saturation limits and the FSM state enum.
REQ-028 The one-cycle registered multiply SHALL be a sub-module named q16_mult_pipe, parameterised by XBITS, with clk, rstn, a, b and p ports.
REQ-029 The counter, FSM, accumulator and output stage SHALL reside in mac_sequencer. The design SHALL contain no combinational path from start to addr.

Verification
REQ-030 N_INPUTS=4, all w=0x00010000, all x=0x00020000, bias=0x00008000 -> result=0x00088000 and done exactly 8 cycles after start.
REQ-031 N_INPUTS=4, w=0x00010000, x=0xFFFF0000, bias=0 -> sum -4.0, so result=0x00000000.
REQ-032 N_INPUTS=4, w=x=0x7FFFFFFF, bias=0 -> result=0x7FFFFFFF (saturated).
REQ-033 Floor check, N_INPUTS=2: pairs (0x00000001,0x00000001) and (0xFFFFFFFF,0x00000001) give products 0 and -1. With bias=0x00000002 -> result=0x00000001.
REQ-034 Pulse start again at cycle 3 of a run -> ignored: one done only, result unchanged from REQ-030. Drop rstn at cycle 4 -> busy=0, done never asserts, result=0, and a fresh start gives 0x00088000.
REQ-035 N_INPUTS=1, w=0x00030000, x=0x00020000, bias=0 -> result=0x00060000 and done 5 cycles after start. Back-to-back start in the done cycle -> second done 5 cycles later.
